// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: byte handshake plus per-frame line configuration for uart_tx_cfg.
//   tx_valid/tx_ready : valid/ready handshake, accept when both high
//   tx_data           : payload, LSB first
//   baud_set          : 0=9600 1=19200 2=38400 3=57600 4=115200 5..7=9600
//   data_bits         : 00=5 01=6 10=7 11=8
//   parity_mode       : 00=none 01=odd 10=even 11=none
//   stop2             : 0=one stop bit, 1=two
// master = byte producer, slave = transmitter.
interface uart_tx_cfg_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [2:0] baud_set;
  logic [1:0] data_bits;
  logic [1:0] parity_mode;
  logic       stop2;

  modport master (output tx_valid, tx_data, baud_set, data_bits, parity_mode, stop2,
                  input  tx_ready);
  modport slave  (input  tx_valid, tx_data, baud_set, data_bits, parity_mode, stop2,
                  output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5..8 data bits, none/odd/even
// parity, 1 or 2 stop bits, five baud rates from a fixed clock).
//   clk      : system clock, rising edge
//   rstn     : asynchronous active-low reset
//   bus      : uart_tx_cfg_if.slave handshake + per-frame configuration
//   uart_tx  : serial line, idle high (registered)
//   tx_busy  : frame in progress
//   tx_done  : one-cycle pulse when the frame completes
module uart_tx_cfg #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_cfg_if.slave  bus,
  output logic          uart_tx,
  output logic          tx_busy,
  output logic          tx_done
);

  // Bit time is div+1 cycles.
  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_HZ / 9600   - 1);
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_HZ / 19200  - 1);
  localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_HZ / 38400  - 1);
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_HZ / 57600  - 1);
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_HZ / 115200 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  function automatic logic [DIV_W-1:0] div_of(input logic [2:0] bs);
    case (bs)
      3'd1:    return DIV_19200;
      3'd2:    return DIV_38400;
      3'd3:    return DIV_57600;
      3'd4:    return DIV_115200;
      default: return DIV_9600;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       last_idx_q, last_idx_d;   // N-1
  logic [7:0]       data_q, data_d;
  logic [1:0]       par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             stop_idx_q, stop_idx_d;
  logic             line_q, line_d;
  logic             done_q, done_d;
  logic             rdy_en_q, rdy_en_d;

  logic       accept, bit_end, stop_exit, par_en, par_bit;
  logic [7:0] mask;

  assign bus.tx_ready = rdy_en_q && (state_q == IDLE);
  assign tx_busy      = (state_q != IDLE);
  assign tx_done      = done_q;
  assign uart_tx      = line_q;

  assign accept  = bus.tx_valid && bus.tx_ready;
  assign bit_end = (cnt_q == div_q);
  assign par_en  = (par_q == 2'b01) || (par_q == 2'b10);
  assign mask    = 8'hFF >> (3'd7 - last_idx_q);
  // Odd mode inverts the data XOR so the total ones count comes out odd.
  assign par_bit = (^(data_q & mask)) ^ (par_q == 2'b01);

  // The final stop bit leaves STOP one cycle before its bit time ends: the
  // line is already high and IDLE keeps it high, so a lone frame still sees a
  // full stop bit, while a byte accepted in the tx_done cycle starts exactly
  // one bit time after the stop bit began. With div=0 there is no earlier
  // cycle, so the exit falls on the bit boundary instead.
  assign stop_exit = (stop_idx_q == stop2_q) &&
                     ((div_q == '0) ? 1'b1 : (cnt_q == div_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    data_d     = data_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    line_d     = line_q;
    done_d     = 1'b0;
    rdy_en_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        line_d = 1'b1;
        if (accept) begin
          data_d     = bus.tx_data;
          div_d      = div_of(bus.baud_set);
          last_idx_d = 3'd4 + {1'b0, bus.data_bits};
          par_d      = bus.parity_mode;
          stop2_d    = bus.stop2;
          state_d    = START;
          line_d     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          line_d    = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx_q) begin
            stop_idx_d = 1'b0;
            if (par_en) begin
              state_d = PARITY;
              line_d  = par_bit;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            line_d    = data_q[bit_idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          line_d     = 1'b1;
        end
      end
      STOP: begin
        line_d = 1'b1;
        if (stop_exit) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      last_idx_q <= '0;
      data_q     <= '0;
      par_q      <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      last_idx_q <= last_idx_d;
      data_q     <= data_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      line_q     <= line_d;
      done_q     <= done_d;
      rdy_en_q   <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed + randomized frames against a bit-list reference
// model; bit time is CLK_HZ/baud cycles (5208 at 9600, 434 at 115200).
module tb_uart_tx_cfg;
  localparam int CLK_HZ = 50000000;

  logic clk, rstn;
  logic uart_tx, tx_busy, tx_done;
  int   tests, fails;
  bit   exp_q[$];

  uart_tx_cfg_if bus();

  uart_tx_cfg #(.CLK_HZ(CLK_HZ), .DIV_W(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bit_time(input int bs);
    int rate;
    case (bs)
      1: rate = 19200;
      2: rate = 38400;
      3: rate = 57600;
      4: rate = 115200;
      default: rate = 9600;
    endcase
    return CLK_HZ / rate;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame as a list of line levels, one per bit time.
  task automatic build_frame(input logic [7:0] d, input int db, input int pm, input int s2);
    int n, ones;
    n = 5 + db;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 1) exp_q.push_back((ones % 2) == 0);
    if (pm == 2) exp_q.push_back((ones % 2) == 1);
    exp_q.push_back(1'b1);
    if (s2 != 0) exp_q.push_back(1'b1);
  endtask

  // Presents a byte, then returns right after the accept edge.
  task automatic send(input logic [7:0] d, input int bs, input int db, input int pm, input int s2);
    @(negedge clk);
    bus.tx_data = d; bus.baud_set = 3'(bs); bus.data_bits = 2'(db);
    bus.parity_mode = 2'(pm); bus.stop2 = 1'(s2); bus.tx_valid = 1'b1;
    chk("ready_before_accept", 32'(bus.tx_ready), 32'd1);
    @(posedge clk);
  endtask

  // Checks every cycle of the frame in exp_q starting the cycle after accept.
  // In the first cycle: tx_valid <= keep, tx_data <= nxt; scramble rewrites config.
  task automatic check_frame(input string tag, input int bt, input logic keep,
                             input logic [7:0] nxt, input logic scramble);
    int f, done_bad, busy_bad, bad, k;
    f = exp_q.size();
    done_bad = 0; busy_bad = 0;
    for (int b = 0; b < f; b++) begin
      bad = 0;
      for (int c = 0; c < bt; c++) begin
        @(negedge clk);
        k = b * bt + c;
        if (k == 0) begin
          bus.tx_valid = keep;
          bus.tx_data  = nxt;
          if (scramble) begin
            bus.baud_set = 3'd3; bus.data_bits = 2'b11;
            bus.parity_mode = 2'b01; bus.stop2 = 1'b0;
          end
        end
        if (uart_tx !== exp_q[b]) bad++;
        if (tx_done !== (k == f * bt - 1)) done_bad++;
        if (tx_busy !== (k != f * bt - 1)) busy_bad++;
      end
      chk($sformatf("%s_bit%0d_badcycles", tag, b), 32'(bad), 32'd0);
    end
    chk({tag, "_done_badcycles"}, 32'(done_bad), 32'd0);
    chk({tag, "_busy_badcycles"}, 32'(busy_bad), 32'd0);
    chk({tag, "_ready_in_done"}, 32'(bus.tx_ready), 32'd1);
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    chk({tag, "_idle_line"}, 32'(uart_tx), 32'd1);
    chk({tag, "_idle_done"}, 32'(tx_done), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    int rdb, rpm, rs2, dpulse;
    tests = 0; fails = 0;
    rstn = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.baud_set = '0;
    bus.data_bits = '0; bus.parity_mode = '0; bus.stop2 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(uart_tx), 32'd1);
    chk("rst_ready", 32'(bus.tx_ready), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rstn = 1'b1;
    #1 chk("ready_before_first_edge", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_first_edge", 32'(bus.tx_ready), 32'd1);
    chk("busy_after_first_edge", 32'(tx_busy), 32'd0);

    // 0x55 8N1 @115200
    send(8'h55, 4, 3, 0, 0);
    build_frame(8'h55, 3, 0, 0);
    chk("f55_len", 32'(exp_q.size() * bit_time(4)), 32'd4340);
    check_frame("f55", bit_time(4), 1'b0, 8'h55, 1'b0);
    idle_after("f55");

    // 0xA5 8E1, config scrambled mid-frame; next frame uses the new config
    send(8'hA5, 4, 3, 2, 0);
    build_frame(8'hA5, 3, 2, 0);
    chk("fa5e_parity", 32'(exp_q[9]), 32'd0);
    check_frame("fa5e", bit_time(4), 1'b0, 8'hA5, 1'b1);
    idle_after("fa5e");
    @(negedge clk);
    bus.tx_valid = 1'b1;
    @(posedge clk);
    build_frame(8'hA5, 3, 1, 0);
    chk("fa5o_parity", 32'(exp_q[9]), 32'd1);
    check_frame("fa5o_b57600", bit_time(3), 1'b0, 8'hA5, 1'b0);
    idle_after("fa5o");

    // 0xE3 5 bits odd, 2 stop @9600
    send(8'hE3, 0, 0, 1, 1);
    build_frame(8'hE3, 0, 1, 1);
    check_frame("fe3", bit_time(0), 1'b0, 8'hE3, 1'b0);
    idle_after("fe3");

    // Back-to-back 0x0F then 0xF0, tx_valid held
    send(8'h0F, 4, 3, 0, 0);
    build_frame(8'h0F, 3, 0, 0);
    check_frame("b2b0", bit_time(4), 1'b1, 8'hF0, 1'b0);
    build_frame(8'hF0, 3, 0, 0);
    check_frame("b2b1", bit_time(4), 1'b0, 8'hF0, 1'b0);
    idle_after("b2b");

    // Random frame
    rd = 8'($urandom_range(0, 255));
    rdb = $urandom_range(0, 3); rpm = $urandom_range(0, 3); rs2 = $urandom_range(0, 1);
    send(rd, 4, rdb, rpm, rs2);
    build_frame(rd, rdb, rpm, rs2);
    check_frame("rand", bit_time(4), 1'b0, rd, 1'b0);
    idle_after("rand");

    // Reset in the middle of data bit 3
    rd = 8'($urandom_range(0, 255));
    send(rd, 4, 3, 0, 0);
    dpulse = 0;
    for (int k = 0; k < 4 * bit_time(4) + 200; k++) begin
      @(negedge clk);
      bus.tx_valid = 1'b0;
      if (tx_done) dpulse++;
    end
    rstn = 1'b0;
    #1;
    chk("midrst_line", 32'(uart_tx), 32'd1);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    chk("midrst_ready", 32'(bus.tx_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tx_done) dpulse++;
    end
    chk("midrst_no_done", 32'(dpulse), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", 32'(bus.tx_ready), 32'd1);
    send(8'h3C, 4, 3, 0, 0);
    build_frame(8'h3C, 3, 0, 0);
    check_frame("f3c", bit_time(4), 1'b0, 8'h3C, 1'b0);
    idle_after("f3c");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
